// File: rtl/map_read_arbiter.sv
// ---------------------------------------------------------------------------
// map_read_arbiter
//
// Purpose: shares one map BRAM read port between NUM_REQ DDA FSMs. It grants
// at most one eligible requester per cycle in round-robin order and registers
// that requester's address onto the BRAM. The read data comes back some
// cycles later and is returned on a shared data bus, tagged with a one-hot
// valid.
//
// Handshake: req_in[i] is a level. A requester is eligible while req_in[i]
// is high and it has no read outstanding. grant_out[i] pulses for one cycle
// when its read is issued. data_valid_out[i] pulses for one cycle exactly
// READ_LATENCY+1 cycles after that grant, and qualifies data_out. A
// requester that holds req_in high is granted again no earlier than the
// cycle after its data_valid_out pulse.
//
// Ports:
//   pixel_clk_in        sole clock, rising edge
//   rst_in              synchronous active-high reset
//   req_in[NUM_REQ]     per-requester read request (level)
//   addr_in             flat address bus, slice i belongs to requester i
//   grant_out           one-hot issue strobe
//   data_out            read data shared by all requesters (held when idle)
//   data_valid_out      one-hot data qualifier
//   map_select_in       0 = map_data1_in, 1 = map_data2_in, sampled at issue
//   map_addra_out       registered BRAM address (held when no grant)
//   map_data1_in/2_in   BRAM read data
//   busy_out            high while any read is in flight
//
// Optional feature (macro MAP_ARB_STATS_EN): adds saturating 16-bit
// grant_count_out and conflict_count_out (cycles with two or more eligible
// requesters).
// ---------------------------------------------------------------------------
module map_read_arbiter #(
   parameter int  NUM_REQ      = 2,
   parameter int  N            = 24,
   parameter int  DATA_W       = 4,
   parameter int  READ_LATENCY = 2,
   localparam int ADDR_W       = $clog2(N*N)
) (
   input  logic                      pixel_clk_in,
   input  logic                      rst_in,
   input  logic [NUM_REQ-1:0]        req_in,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
   output logic [NUM_REQ-1:0]        grant_out,
   output logic [DATA_W-1:0]         data_out,
   output logic [NUM_REQ-1:0]        data_valid_out,
   input  logic                      map_select_in,
   output logic [ADDR_W-1:0]         map_addra_out,
   input  logic [DATA_W-1:0]         map_data1_in,
   input  logic [DATA_W-1:0]         map_data2_in,
   output logic                      busy_out
`ifdef MAP_ARB_STATS_EN
   ,
   output logic [15:0]               grant_count_out,
   output logic [15:0]               conflict_count_out
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // The tag chain has one stage for the address cycle plus READ_LATENCY
   // stages for the BRAM, so its last stage lines up with the BRAM data.
   localparam int DEPTH = READ_LATENCY + 1;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic             sel;
   } tag_t;

   logic [NUM_REQ-1:0] pending_q;
   logic [IDX_W-1:0]   last_q;
   tag_t               tag_q [DEPTH];

   logic [NUM_REQ-1:0] eligible;
   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [IDX_W-1:0]   cand;
   int                 cand_i;
   logic [ADDR_W-1:0]  win_addr;
   logic [NUM_REQ-1:0] win_vec;
   logic [NUM_REQ-1:0] dv_vec;
   tag_t               tag_in;

   // Round-robin search, starting one past the last granted requester.
   always_comb begin
      eligible  = req_in & ~pending_q;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      cand_i    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_i = int'(last_q) + k;
         if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
         cand = IDX_W'(cand_i);
         if (!win_found && eligible[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) win_addr = addr_in[i*ADDR_W +: ADDR_W];
      end
   end

   always_comb begin
      win_vec      = win_found ? (NUM_REQ'(1) << win_idx) : '0;
      dv_vec       = NUM_REQ'(1) << tag_q[DEPTH-1].idx;
      tag_in.valid = win_found;
      tag_in.idx   = win_idx;
      tag_in.sel   = map_select_in;
   end

   always_comb begin
      busy_out = 1'b0;
      for (int s = 0; s < DEPTH; s++) busy_out = busy_out | tag_q[s].valid;
   end

   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         grant_out      <= '0;
         data_valid_out <= '0;
         data_out       <= '0;
         map_addra_out  <= '0;
         pending_q      <= '0;
         last_q         <= IDX_W'(NUM_REQ - 1);
         for (int s = 0; s < DEPTH; s++) tag_q[s] <= '0;
      end else begin
         grant_out <= win_vec;
         tag_q[0]  <= tag_in;
         for (int s = 1; s < DEPTH; s++) tag_q[s] <= tag_q[s-1];
         if (win_found) begin
            map_addra_out <= win_addr;
            last_q        <= win_idx;
         end

         // The map choice travels with the tag, so toggling map_select_in
         // after issue has no effect on reads already in flight.
         data_valid_out <= '0;
         if (tag_q[DEPTH-1].valid) begin
            data_valid_out <= dv_vec;
            data_out       <= tag_q[DEPTH-1].sel ? map_data2_in : map_data1_in;
         end

         // A pending bit drops on the edge that ends its data_valid_out
         // pulse. A grant never lands on a pending requester, so the set
         // and the clear never touch the same bit.
         pending_q <= (pending_q & ~data_valid_out) | win_vec;
      end
   end

`ifdef MAP_ARB_STATS_EN
   always_ff @(posedge pixel_clk_in) begin
      if (rst_in) begin
         grant_count_out    <= '0;
         conflict_count_out <= '0;
      end else begin
         if (win_found && grant_count_out != 16'hFFFF)
            grant_count_out <= grant_count_out + 16'd1;
         if ($countones(eligible) >= 2 && conflict_count_out != 16'hFFFF)
            conflict_count_out <= conflict_count_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_map_read_arbiter.sv
module tb_map_read_arbiter;

   localparam int NR   = 2;
   localparam int N    = 24;
   localparam int DW   = 4;
   localparam int RL   = 2;
   localparam int AW   = $clog2(N*N);
   localparam int MAXC = 4096;

   // ---------------- clock / reset ----------------
   logic pixel_clk_in = 1'b0;
   always #5 pixel_clk_in = ~pixel_clk_in;

   logic              rst_in;
   logic [NR-1:0]     req_in;
   logic [NR*AW-1:0]  addr_in;
   logic [NR-1:0]     grant_out;
   logic [DW-1:0]     data_out;
   logic [NR-1:0]     data_valid_out;
   logic              map_select_in;
   logic [AW-1:0]     map_addra_out;
   logic [DW-1:0]     map_data1_in;
   logic [DW-1:0]     map_data2_in;
   logic              busy_out;
`ifdef MAP_ARB_STATS_EN
   logic [15:0]       grant_count_out;
   logic [15:0]       conflict_count_out;
`endif

   map_read_arbiter #(
      .NUM_REQ(NR), .N(N), .DATA_W(DW), .READ_LATENCY(RL)
   ) dut (
      .pixel_clk_in   (pixel_clk_in),
      .rst_in         (rst_in),
      .req_in         (req_in),
      .addr_in        (addr_in),
      .grant_out      (grant_out),
      .data_out       (data_out),
      .data_valid_out (data_valid_out),
      .map_select_in  (map_select_in),
      .map_addra_out  (map_addra_out),
      .map_data1_in   (map_data1_in),
      .map_data2_in   (map_data2_in),
      .busy_out       (busy_out)
`ifdef MAP_ARB_STATS_EN
      ,
      .grant_count_out    (grant_count_out),
      .conflict_count_out (conflict_count_out)
`endif
   );

   // ---------------- BRAM model: RL cycles from address to data ----------------
   logic [DW-1:0] mem1 [N*N];
   logic [DW-1:0] mem2 [N*N];
   logic [AW-1:0] a_q  [RL];

   always @(posedge pixel_clk_in) begin
      a_q[0] <= map_addra_out;
      for (int k = 1; k < RL; k++) a_q[k] <= a_q[k-1];
   end

   always_comb begin
      map_data1_in = '0;
      map_data2_in = '0;
      if (int'(a_q[RL-1]) < N*N) begin
         map_data1_in = mem1[a_q[RL-1]];
         map_data2_in = mem2[a_q[RL-1]];
      end
   end

   // ---------------- scoreboard counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   int cur_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur_cyc, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input logic [NR-1:0] req, input bit sel,
                        input logic [NR*AW-1:0] ab);
      rst_in        = rst;
      req_in        = req;
      map_select_in = sel;
      addr_in       = ab;
   endtask

   function automatic logic [NR*AW-1:0] pack2(input int a0, input int a1);
      logic [NR*AW-1:0] r;
      r = {AW'(a1), AW'(a0)};
      return r;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      bit        rst;
      bit [1:0]  req;
      bit        sel;
      int        a0;
      int        a1;
      bit        chk;
      bit [1:0]  g;
      bit [1:0]  dv;
      int        d;
      bit        busy;
      int        addr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit rst, bit [1:0] req, bit sel, int a0, int a1, bit chk,
                               bit [1:0] g, bit [1:0] dv, int d, bit busy, int addr);
      vec_t v;
      v.rst = rst; v.req = req; v.sel = sel; v.a0 = a0; v.a1 = a1; v.chk = chk;
      v.g = g; v.dv = dv; v.d = d; v.busy = busy; v.addr = addr;
      return v;
   endfunction

   // ---------------- behavioural reference model ----------------
   // Outcomes are scheduled into per-cycle slots: a decision made in cycle c
   // shows its grant in c+1 and its data in c+RL+2; the requester is free
   // again from c+RL+3.
   logic [NR-1:0] m_grant  [MAXC];
   logic [NR-1:0] m_dv     [MAXC];
   int            m_busy   [MAXC];
   logic [AW-1:0] m_gaddr  [MAXC];
   logic [DW-1:0] m_dvdata [MAXC];
   bit            m_rst    [MAXC];
   int            free_at  [NR];
   int            last_g;
   int            mc;
   logic [DW-1:0] e_data;
   logic [AW-1:0] e_addr;
   int            m_gcnt;
   int            m_ccnt;

   task automatic model_compare();
      if (m_rst[mc]) begin
         e_addr = '0;
         e_data = '0;
      end
      if (m_grant[mc] != '0) e_addr = m_gaddr[mc];
      if (m_dv[mc] != '0)    e_data = m_dvdata[mc];
      if (mc > 0) begin
         check("m_grant", 32'(grant_out),      32'(m_grant[mc]));
         check("m_valid", 32'(data_valid_out), 32'(m_dv[mc]));
         check("m_data",  32'(data_out),       32'(e_data));
         check("m_addr",  32'(map_addra_out),  32'(e_addr));
         check("m_busy",  32'(busy_out),       32'(m_busy[mc] != 0));
      end
   endtask

   task automatic model_predict(input bit rst, input logic [NR-1:0] req, input bit sel,
                                input logic [NR*AW-1:0] ab);
      int ne;
      int w;
      int i;
      int g;
      int d;
      logic [AW-1:0] a;
      if (rst) begin
         for (int j = mc + 1; j <= mc + RL + 3; j++) begin
            m_grant[j] = '0;
            m_dv[j]    = '0;
            m_busy[j]  = 0;
         end
         m_rst[mc+1] = 1'b1;
         for (int r = 0; r < NR; r++) free_at[r] = 0;
         last_g = NR - 1;
         m_gcnt = 0;
         m_ccnt = 0;
      end else begin
         ne = 0;
         w  = -1;
         for (int r = 0; r < NR; r++) if (req[r] && mc >= free_at[r]) ne++;
         if (ne >= 2 && m_ccnt < 65535) m_ccnt++;
         for (int k = 1; k <= NR; k++) begin
            i = (last_g + k) % NR;
            if (w < 0 && req[i] && mc >= free_at[i]) w = i;
         end
         if (w >= 0) begin
            g = mc + 1;
            d = mc + RL + 2;
            a = ab[w*AW +: AW];
            m_grant[g]  = NR'(1) << w;
            m_gaddr[g]  = a;
            m_dv[d]     = NR'(1) << w;
            m_dvdata[d] = sel ? mem2[a] : mem1[a];
            for (int j = g; j < d; j++) m_busy[j]++;
            free_at[w] = d + 1;
            last_g     = w;
            if (m_gcnt < 65535) m_gcnt++;
         end
      end
   endtask

   task automatic mstep(input bit rst, input logic [NR-1:0] req, input bit sel,
                        input logic [NR*AW-1:0] ab);
      @(posedge pixel_clk_in);
      #1;
      cur_cyc = mc;
      model_compare();
      drive(rst, req, sel, ab);
      model_predict(rst, req, sel, ab);
      mc++;
   endtask

   // ---------------- main test ----------------
   initial begin
      for (int a = 0; a < N*N; a++) begin
         mem1[a] = DW'((a * 3 + 1) % 16);
         mem2[a] = DW'((a * 5 + 7) % 16);
      end
      mem1[37] = 4'd5;
      drive(1'b1, '0, 1'b0, '0);

      //        rst req   sel a0 a1  chk grant dv    data busy addr
      tbl.push_back(mk(1, 2'b00, 0,  0, 0, 0, 2'b00, 2'b00,  0, 0,  0));
      tbl.push_back(mk(0, 2'b01, 0, 37, 0, 1, 2'b00, 2'b00,  0, 0,  0));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b01, 2'b00,  0, 1, 37));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  0, 1, 37));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  0, 1, 37));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b01,  5, 0, 37));
      tbl.push_back(mk(0, 2'b01, 0, 10,20, 1, 2'b00, 2'b00,  5, 0, 37));
      tbl.push_back(mk(0, 2'b10, 1, 10,20, 1, 2'b01, 2'b00,  5, 1, 10));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b10, 2'b00,  5, 1, 20));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00,  5, 1, 20));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b01, 15, 1, 20));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b00, 2'b10, 11, 0, 20));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b01, 2'b00, 11, 1,  3));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b10, 2'b00, 11, 1,  4));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b00, 2'b00, 11, 1,  4));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b00, 2'b01, 10, 1,  4));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b00, 2'b10, 13, 0,  4));
      tbl.push_back(mk(0, 2'b11, 0,  3, 4, 1, 2'b01, 2'b00, 13, 1,  3));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b10, 2'b00, 13, 1,  4));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00, 13, 1,  4));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b01, 10, 1,  4));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b10, 13, 0,  4));
      tbl.push_back(mk(0, 2'b00, 0,  0, 0, 1, 2'b00, 2'b00, 13, 0,  4));

      // Each row: outputs observed in this cycle, then inputs driven for it.
      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge pixel_clk_in);
         #1;
         cur_cyc = k;
         if (tbl[k].chk) begin
            check("t_grant", 32'(grant_out),      32'(tbl[k].g));
            check("t_valid", 32'(data_valid_out), 32'(tbl[k].dv));
            check("t_data",  32'(data_out),       32'(tbl[k].d));
            check("t_busy",  32'(busy_out),       32'(tbl[k].busy));
            check("t_addr",  32'(map_addra_out),  32'(tbl[k].addr));
         end
         drive(tbl[k].rst, tbl[k].req, tbl[k].sel, pack2(tbl[k].a0, tbl[k].a1));
      end

      // Model-checked phase: clear the schedule, start with a reset.
      for (int j = 0; j < MAXC; j++) begin
         m_grant[j] = '0; m_dv[j] = '0; m_busy[j] = 0;
         m_gaddr[j] = '0; m_dvdata[j] = '0; m_rst[j] = 1'b0;
      end
      for (int r = 0; r < NR; r++) free_at[r] = 0;
      last_g = NR - 1; mc = 0; e_data = '0; e_addr = '0; m_gcnt = 0; m_ccnt = 0;
      mstep(1'b1, 2'b00, 1'b0, '0);

      // Map select toggles right after issue; data must come from map 1.
      mstep(1'b0, 2'b01, 1'b0, pack2(100, 0));
      mstep(1'b0, 2'b00, 1'b1, '0);
      repeat (6) mstep(1'b0, 2'b00, 1'b1, '0);

      // Reset with two reads in flight and last grant on requester 0.
      mstep(1'b0, 2'b10, 1'b0, pack2(0, 200));
      mstep(1'b0, 2'b01, 1'b1, pack2(300, 0));
      mstep(1'b1, 2'b00, 1'b0, '0);
      repeat (6) mstep(1'b0, 2'b00, 1'b0, '0);
      mstep(1'b0, 2'b11, 1'b0, pack2(11, 12));
      repeat (8) mstep(1'b0, 2'b00, 1'b0, '0);

      // Ten contended cycles, each followed by enough idle time to drain.
      mstep(1'b1, 2'b00, 1'b0, '0);
      for (int n = 0; n < 10; n++) begin
         mstep(1'b0, 2'b11, 1'(n % 2), pack2(n + 40, n + 50));
         repeat (7) mstep(1'b0, 2'b00, 1'b0, '0);
      end
`ifdef MAP_ARB_STATS_EN
      check("conflict_10", 32'(conflict_count_out), 32'd10);
      check("grant_cnt",   32'(grant_count_out),    32'(m_gcnt));
`endif

      // Randomised traffic with occasional mid-flight resets.
      for (int n = 0; n < 1500; n++) begin
         logic [NR-1:0] rq;
         logic [NR*AW-1:0] ab;
         bit rs;
         for (int r = 0; r < NR; r++) begin
            rq[r] = ($urandom_range(0, 3) != 0);
            ab[r*AW +: AW] = AW'($urandom_range(0, N*N - 1));
         end
         rs = ($urandom_range(0, 199) == 0);
         mstep(rs, rq, 1'($urandom_range(0, 1)), ab);
      end
      repeat (8) mstep(1'b0, 2'b00, 1'b0, '0);
`ifdef MAP_ARB_STATS_EN
      check("grant_cnt_rand",    32'(grant_count_out),    32'(m_gcnt));
      check("conflict_cnt_rand", 32'(conflict_count_out), 32'(m_ccnt));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
